// File: rtl/rr_request_encoder_pkg.sv
// Shared types and constants for the round-robin request encoder.
package rr_request_encoder_pkg;

    localparam int DEFAULT_N = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } enc_state_t;

endpackage

// File: rtl/rr_request_encoder_if.sv
// Request/grant bus between the encoder (slave) and the source/consumer side (master).
interface rr_request_encoder_if
    import rr_request_encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    localparam int W = $clog2(N);

    logic         ena;
    logic [N-1:0] req_in;
    logic         ready;
    logic         valid;
    logic [W-1:0] idx_out;
    logic [N-1:0] onehot_out;
    logic         pending_any;

    modport master (
        output ena, req_in, ready,
        input  valid, idx_out, onehot_out, pending_any
    );

    modport slave (
        input  ena, req_in, ready,
        output valid, idx_out, onehot_out, pending_any
    );
endinterface

// File: rtl/rr_request_encoder_pick.sv
// Round-robin picker: first set bit of cand at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] ptr,
    output logic         hit,
    output logic [W-1:0] sel
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then map back to a line index.
    always_comb begin
        dbl = {cand, cand} >> ptr;
        rot = dbl[N-1:0];
        hit = |rot;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
        // ptr + off can exceed N-1; fold back explicitly so non-power-of-2 N wraps correctly.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        sel = sum[W-1:0];
    end
endmodule

// File: rtl/rr_request_encoder.sv
// Latches request pulses and grants pending lines one at a time, round-robin, over valid/ready.
module rr_request_encoder
    import rr_request_encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input logic                 clk,
    input logic                 rst_n,
    rr_request_encoder_if.slave bus
);
    localparam int W = $clog2(N);

    enc_state_t   state;
    logic [N-1:0] pending;
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    logic [N-1:0] nxt_pending;
    logic [N-1:0] sel_oh;
    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic         hit;
    logic         hs;

    // The line being handed off this cycle drops out of the candidates; this cycle's
    // req_in is never a candidate, only a future one.
    assign hs          = bus.valid & bus.ready;
    assign clr         = hs ? bus.onehot_out : '0;
    assign cand        = pending & ~clr;
    assign nxt_pending = cand | bus.req_in;
    assign sel_oh      = N'(1) << sel;

    rr_pick #(.N(N)) u_pick (
        .cand (cand),
        .ptr  (ptr),
        .hit  (hit),
        .sel  (sel)
    );

    // Pending register: clear on handshake, set wins, repeats merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending         <= '0;
            bus.pending_any <= 1'b0;
        end else begin
            pending         <= nxt_pending;
            bus.pending_any <= |nxt_pending;
        end
    end

    // Priority pointer moves just past each line that completes a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (bus.idx_out == W'(N - 1)) ? '0 : bus.idx_out + 1'b1;
        end
    end

    // Grant FSM with registered valid/idx/onehot; a presented grant holds until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.valid      <= 1'b0;
            bus.idx_out    <= '0;
            bus.onehot_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ena && hit) begin
                        bus.valid      <= 1'b1;
                        bus.idx_out    <= sel;
                        bus.onehot_out <= sel_oh;
                        state          <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hs) begin
                        if (bus.ena && hit) begin
                            bus.idx_out    <= sel;
                            bus.onehot_out <= sel_oh;
                        end else begin
                            bus.valid      <= 1'b0;
                            bus.onehot_out <= '0;
                            state          <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed bench: scoreboard of expected grant indices checked at every handshake.
module tb_rr_request_encoder;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];

    rr_request_encoder_if #(.N(N)) bus ();

    rr_request_encoder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: inputs settle at posedge+1, so valid&ready at negedge means a
    // handshake on the coming edge.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                automatic int e = exp_q.pop_front();
                automatic logic [31:0] oh = 32'd1 << e;
                check("sb_idx", 32'(bus.idx_out), 32'(e));
                check("sb_onehot", bus.onehot_out, oh);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus.ena    = 1'b0;
        bus.req_in = '0;
        bus.ready  = 1'b0;
        #3;
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_idx", 32'(bus.idx_out), 0);
        check("rst_onehot", bus.onehot_out, 0);
        check("rst_pend", 32'(bus.pending_any), 0);
        step();
        rst_n = 1'b1;

        // Single pulse on line 4
        bus.ena = 1'b1; bus.ready = 1'b1; bus.req_in = 32'h0000_0010;
        exp_q.push_back(4);
        step();
        bus.req_in = '0;
        check("sp_valid_e1", 32'(bus.valid), 0);
        check("sp_pend_e1", 32'(bus.pending_any), 1);
        step();
        check("sp_valid_e2", 32'(bus.valid), 1);
        check("sp_idx_e2", 32'(bus.idx_out), 4);
        check("sp_oh_e2", bus.onehot_out, 32'h10);
        step();
        check("sp_valid_e3", 32'(bus.valid), 0);
        check("sp_pend_e3", 32'(bus.pending_any), 0);

        // Wrap and back-to-back: ptr=5 now, so 31 comes first, then 0, 1
        bus.req_in = 32'h8000_0003;
        exp_q.push_back(31); exp_q.push_back(0); exp_q.push_back(1);
        step();
        bus.req_in = '0;
        step();
        check("wr_valid0", 32'(bus.valid), 1);
        check("wr_idx0", 32'(bus.idx_out), 31);
        step();
        check("wr_valid1", 32'(bus.valid), 1);
        check("wr_idx1", 32'(bus.idx_out), 0);
        step();
        check("wr_valid2", 32'(bus.valid), 1);
        check("wr_idx2", 32'(bus.idx_out), 1);
        step();
        check("wr_valid_end", 32'(bus.valid), 0);
        check("wr_ptr_end", 32'(dut.ptr), 2);

        // Wrap from reset pointer: reset, then 0, 1, 31 back-to-back, ptr returns to 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req_in = 32'h8000_0003;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(31);
        step();
        bus.req_in = '0;
        step();
        check("wr2_idx0", 32'(bus.idx_out), 0);
        step();
        check("wr2_idx1", 32'(bus.idx_out), 1);
        check("wr2_valid1", 32'(bus.valid), 1);
        step();
        check("wr2_idx2", 32'(bus.idx_out), 31);
        check("wr2_valid2", 32'(bus.valid), 1);
        step();
        check("wr2_valid_end", 32'(bus.valid), 0);
        check("wr2_ptr_end", 32'(dut.ptr), 0);

        // Fairness: grant line 1 to park ptr at 2, then hammer lines 1 and 5
        bus.req_in = 32'h2;
        exp_q.push_back(1);
        step();
        bus.req_in = '0;
        step();
        step();
        check("fa_ptr", 32'(dut.ptr), 2);
        bus.req_in = 32'h22;
        exp_q.push_back(5); exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(1);
        step();
        step();
        check("fa_g0", 32'(bus.idx_out), 5);
        step();
        check("fa_g1", 32'(bus.idx_out), 1);
        step();
        bus.req_in = '0;
        check("fa_g2", 32'(bus.idx_out), 5);
        step();
        check("fa_g3", 32'(bus.idx_out), 1);
        step();
        check("fa_valid_end", 32'(bus.valid), 0);
        check("fa_pend_end", 32'(bus.pending_any), 0);

        // Backpressure: hold grant 3 while ready=0, ena toggling, line 0 arriving
        bus.ready = 1'b0; bus.req_in = 32'h8;
        exp_q.push_back(3); exp_q.push_back(0);
        step();
        bus.req_in = '0;
        step();
        check("bp_idx_start", 32'(bus.idx_out), 3);
        for (int i = 0; i < 5; i++) begin
            bus.ena    = i[0];
            bus.req_in = (i == 0) ? 32'h1 : 32'h0;
            step();
            check("bp_hold_valid", 32'(bus.valid), 1);
            check("bp_hold_idx", 32'(bus.idx_out), 3);
            check("bp_hold_oh", bus.onehot_out, 32'h8);
        end
        bus.req_in = '0; bus.ena = 1'b1; bus.ready = 1'b1;
        step();
        check("bp_next_valid", 32'(bus.valid), 1);
        check("bp_next_idx", 32'(bus.idx_out), 0);
        step();
        check("bp_valid_end", 32'(bus.valid), 0);

        // Enable gating: requests latch while ena=0, grant follows when ena rises
        bus.ena = 1'b0; bus.req_in = 32'h4;
        exp_q.push_back(2);
        step();
        bus.req_in = '0;
        step();
        check("en_valid_lo", 32'(bus.valid), 0);
        check("en_pend_lo", 32'(bus.pending_any), 1);
        step();
        check("en_valid_lo2", 32'(bus.valid), 0);
        bus.ena = 1'b1;
        step();
        check("en_valid_hi", 32'(bus.valid), 1);
        check("en_idx_hi", 32'(bus.idx_out), 2);
        check("en_oh_hi", bus.onehot_out, 32'h4);
        step();
        check("en_valid_end", 32'(bus.valid), 0);

        // Reset mid-hold: lines 0 and 3 pending, ptr=3 so 3 is presented, then reset
        bus.ready = 1'b0; bus.req_in = 32'h9;
        step();
        bus.req_in = '0;
        step();
        check("rh_valid", 32'(bus.valid), 1);
        check("rh_idx", 32'(bus.idx_out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rh_rst_valid", 32'(bus.valid), 0);
        check("rh_rst_idx", 32'(bus.idx_out), 0);
        check("rh_rst_oh", bus.onehot_out, 0);
        check("rh_rst_pend", 32'(bus.pending_any), 0);
        step();
        rst_n = 1'b1; bus.ready = 1'b1;
        step();
        step();
        check("rh_after_valid", 32'(bus.valid), 0);
        check("rh_after_pend", 32'(bus.pending_any), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
